// File: rtl/ascon_pkg.sv
// Shared widths, derived frame length and FSM state encoding for the Ascon serial loader.
package ascon_pkg;

  localparam int unsigned K  = 128;
  localparam int unsigned L  = 40;
  localparam int unsigned Y  = 104;
  localparam int unsigned NW = 128;

  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  localparam int unsigned MAX = max4(K, NW, L, Y);
  localparam int unsigned CW  = $clog2(MAX + 1);

  typedef enum logic [1:0] {
    StLoad,
    StArmed,
    StRun,
    StDone
  } state_e;

endpackage

// File: rtl/ascon_sipo.sv
// Serial-in/parallel-out field register; shifts MSB-first only while the shared bit count is
// below its own width, so shorter fields freeze once full.
module ascon_sipo #(
  parameter int unsigned W  = 8,
  parameter int unsigned CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [CW-1:0] cnt,
  input  logic          sin,
  output logic [W-1:0]  q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (en && (32'(cnt) < W)) begin
      q_d = {q_q[W-2:0], sin};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/ascon_serial_loader.sv
// Deserialises key/nonce/AD/text into parallel registers, then fires one start pulse to the
// Ascon core on a fresh start edge and reports completion until reset.
module ascon_serial_loader
  import ascon_pkg::*;
#(
  parameter int unsigned K = ascon_pkg::K,
  parameter int unsigned L = ascon_pkg::L,
  parameter int unsigned Y = ascon_pkg::Y
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          shift_en_i,
  input  logic          key_si,
  input  logic          nonce_si,
  input  logic          ad_si,
  input  logic          data_si,
  input  logic          ascon_start_si,
  input  logic          decrypt_i,
  input  logic          core_ready_i,
  output logic [K-1:0]  key_o,
  output logic [NW-1:0] nonce_o,
  output logic [L-1:0]  ad_o,
  output logic [Y-1:0]  data_o,
  output logic          decrypt_o,
  output logic          core_start_o,
  output logic          loaded_o,
  output logic          done_o,
  output logic          load_err_o
);

  localparam int unsigned Max  = max4(K, NW, L, Y);
  localparam int unsigned CntW = $clog2(Max + 1);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              start_q;
  logic              loaded_q, loaded_d;
  logic              done_q, done_d;
  logic              core_start_q, core_start_d;
  logic              decrypt_q, decrypt_d;
  logic              err_q, err_d;
  logic              shift;
  logic              rise;

  assign rise = ascon_start_si & ~start_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    loaded_d     = loaded_q;
    done_d       = done_q;
    core_start_d = 1'b0;
    decrypt_d    = decrypt_q;
    err_d        = err_q;
    shift        = 1'b0;
    unique case (state_q)
      StLoad: begin
        if (rise) err_d = 1'b1;
        if (shift_en_i) begin
          shift = 1'b1;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntW'(Max - 1)) begin
            loaded_d = 1'b1;
            state_d  = StArmed;
          end
        end
      end
      StArmed: begin
        if (rise) begin
          decrypt_d    = decrypt_i;
          core_start_d = 1'b1;
          state_d      = StRun;
        end
      end
      StRun: begin
        // The pulse-asserting edge was in StArmed, so ready is only seen from here on.
        if (core_ready_i) begin
          done_d  = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
      end
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StLoad;
      cnt_q        <= '0;
      start_q      <= 1'b0;
      loaded_q     <= 1'b0;
      done_q       <= 1'b0;
      core_start_q <= 1'b0;
      decrypt_q    <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      start_q      <= ascon_start_si;
      loaded_q     <= loaded_d;
      done_q       <= done_d;
      core_start_q <= core_start_d;
      decrypt_q    <= decrypt_d;
      err_q        <= err_d;
    end
  end

  ascon_sipo #(.W(K), .CW(CntW)) u_key (
    .clk (clk),
    .rst (rst),
    .en  (shift),
    .cnt (cnt_q),
    .sin (key_si),
    .q   (key_o)
  );

  ascon_sipo #(.W(NW), .CW(CntW)) u_nonce (
    .clk (clk),
    .rst (rst),
    .en  (shift),
    .cnt (cnt_q),
    .sin (nonce_si),
    .q   (nonce_o)
  );

  ascon_sipo #(.W(L), .CW(CntW)) u_ad (
    .clk (clk),
    .rst (rst),
    .en  (shift),
    .cnt (cnt_q),
    .sin (ad_si),
    .q   (ad_o)
  );

  ascon_sipo #(.W(Y), .CW(CntW)) u_data (
    .clk (clk),
    .rst (rst),
    .en  (shift),
    .cnt (cnt_q),
    .sin (data_si),
    .q   (data_o)
  );

  assign decrypt_o    = decrypt_q;
  assign core_start_o = core_start_q;
  assign loaded_o     = loaded_q;
  assign done_o       = done_q;
  assign load_err_o   = err_q;

endmodule
